// File: rtl/pipe_add_pkg.sv
// Shared constants and types for the credit-gated issue stage in front of a pipelined 4-bit adder.
package pipe_add_pkg;

  localparam int ADD_LAT    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int OP_W       = 4;
  localparam int RES_W      = 5;

  typedef logic [OP_W-1:0]  operand_t;
  typedef logic [RES_W-1:0] result_t;

endpackage

// File: rtl/pipe_add_fifo.sv
// Result FIFO. The issue stage guarantees a push never meets a full FIFO and a pop never meets an empty one.
module pipe_add_fifo
  import pipe_add_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  result_t          din,
  input  logic             pop,
  output result_t          dout,
  output logic [CNT_W-1:0] count
);

  result_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is not reset; an entry only has meaning once count covers it.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      unique case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Empty head reads as zero so stale storage never shows on the output.
  assign dout  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count = r_count;

endmodule

// File: rtl/pipe_add_issue.sv
// Issues operands to an external fixed-latency adder and tracks them with a tag shift register;
// credits cover in-flight plus buffered results so the capture FIFO can never overflow.
module pipe_add_issue
  import pipe_add_pkg::*;
#(
  parameter int LAT   = ADD_LAT,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_ci,
  output logic [OP_W-1:0]  add_a,
  output logic [OP_W-1:0]  add_b,
  output logic             add_ci,
  input  logic [OP_W-1:0]  add_s,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_sum,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CRD_W = $clog2(LAT + DEPTH + 1);

  logic [LAT-1:0]   r_tag;
  logic             w_accept;
  logic             w_pop;
  logic [CNT_W-1:0] w_fifo_count;
  logic [CRD_W-1:0] w_inflight;
  logic [CRD_W-1:0] w_credit_used;

  // NOTE: combinational blocks use blocking '=' with a default first (no latch); clocked state uses '<='.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + CRD_W'(r_tag[i]);
    end
  end

  // Credit is taken from registered state only, so a pop frees its slot one cycle later.
  assign w_credit_used = w_inflight + CRD_W'(w_fifo_count);
  assign in_ready      = rstn && (w_credit_used < CRD_W'(DEPTH));
  assign w_accept      = in_valid && in_ready;

  assign add_a  = w_accept ? in_a  : '0;
  assign add_b  = w_accept ? in_b  : '0;
  assign add_ci = w_accept ? in_ci : 1'b0;

  always_ff @(posedge clk) begin
    if (!rstn) r_tag <= '0;
    else       r_tag <= (r_tag << 1) | LAT'(w_accept);
  end

  pipe_add_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (r_tag[LAT-1]),
    .din   ({add_co, add_s}),
    .pop   (w_pop),
    .dout  (out_sum),
    .count (w_fifo_count)
  );

  assign out_valid = (w_fifo_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign busy      = (r_tag != '0) || out_valid;

endmodule

// File: tb/tb_pipe_add_issue.sv
// Scoreboard bench: a 4-stage pipelined adder model feeds the DUT; accepted operations push
// hand-computed sums into a queue that a negedge monitor pops on every output handshake.
module tb_pipe_add_issue;
  import pipe_add_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       in_ci = 1'b0;
  logic [3:0] add_a, add_b, add_s;
  logic       add_ci, add_co;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_sum;
  logic       busy;

  logic [4:0] adder_pipe [ADD_LAT];
  logic [4:0] exp_q [$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         wrap_done = 1'b0;

  always #5 clk = ~clk;

  pipe_add_issue dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  // Pipelined adder: operands captured on an edge appear ADD_LAT-1 edges later at the last stage.
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < ADD_LAT; i++) adder_pipe[i] <= '0;
    end else begin
      adder_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};
      for (int i = 1; i < ADD_LAT; i++) adder_pipe[i] <= adder_pipe[i-1];
    end
  end
  assign add_s  = adder_pipe[ADD_LAT-1][3:0];
  assign add_co = adder_pipe[ADD_LAT-1][4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got %0d, want no result", out_sum);
      end else begin
        check("result", 32'(out_sum), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic [4:0] exp);
    bit done;
    done     = 1'b0;
    in_a     = a;
    in_b     = b;
    in_ci    = ci;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        check("adder_operands", {23'd0, add_a, add_b, add_ci}, {23'd0, a, b, ci});
        exp_q.push_back(exp);
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no accept, want accept of %0d+%0d+%0d", a, b, ci);
    end
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_ci    = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, and reset-state outputs
    rstn = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_add_ops", {23'd0, add_a, add_b, add_ci}, 32'd0);
    tick();

    // Single op: latency 4, valid for one cycle, busy drops after pop
    out_ready = 1'b1;
    send(4'd9, 4'd8, 1'b1, 5'd18);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("lat_not_yet", 32'(out_valid), 32'd0);
      check("lat_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_sum", 32'(out_sum), 32'd18);
    @(negedge clk);
    check("single_one_cycle", 32'(out_valid), 32'd0);
    check("single_busy_done", 32'(busy), 32'd0);
    tick();

    // Back-to-back issue, results on consecutive cycles
    send(4'd15, 4'd15, 1'b1, 5'd31);
    send(4'd0,  4'd0,  1'b0, 5'd0);
    send(4'd7,  4'd8,  1'b0, 5'd15);
    send(4'd3,  4'd4,  1'b1, 5'd8);
    @(negedge clk);
    check("b2b_not_yet", 32'(out_valid), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("b2b_consecutive", 32'(out_valid), 32'd1);
    end
    wait_drain("b2b_drain");

    // Backpressure: credit stops at DEPTH, then one accept per pop
    out_ready = 1'b0;
    send(4'd1,  4'd2, 1'b0, 5'd3);
    send(4'd4,  4'd5, 1'b1, 5'd10);
    send(4'd15, 4'd0, 1'b1, 5'd16);
    send(4'd8,  4'd8, 1'b0, 5'd16);
    in_a = 4'd6; in_b = 4'd6; in_ci = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    check("bp_fifo_holding", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b1;
    send(4'd6,  4'd6, 1'b1, 5'd13);
    send(4'd10, 4'd3, 1'b0, 5'd13);
    wait_drain("bp_drain");

    // Pointer wrap with out_ready toggling every cycle
    out_ready = 1'b0;
    fork
      begin
        send(4'd0,  4'd1,  1'b0, 5'd1);
        send(4'd2,  4'd3,  1'b0, 5'd5);
        send(4'd4,  4'd5,  1'b1, 5'd10);
        send(4'd6,  4'd7,  1'b0, 5'd13);
        send(4'd8,  4'd9,  1'b1, 5'd18);
        send(4'd10, 4'd11, 1'b0, 5'd21);
        send(4'd12, 4'd13, 1'b1, 5'd26);
        send(4'd14, 4'd15, 1'b0, 5'd29);
        send(4'd1,  4'd1,  1'b1, 5'd3);
        send(4'd3,  4'd3,  1'b0, 5'd6);
        send(4'd5,  4'd9,  1'b1, 5'd15);
        send(4'd11, 4'd9,  1'b0, 5'd20);
        wait_drain("wrap_drain");
        wrap_done = 1'b1;
      end
      begin
        while (!wrap_done) begin
          tick();
          out_ready = ~out_ready;
        end
      end
    join

    // Reset mid-flight: one result buffered, two in the adder
    out_ready = 1'b0;
    send(4'd2, 4'd2, 1'b0, 5'd4);
    tick();
    tick();
    send(4'd5, 4'd5, 1'b0, 5'd10);
    send(4'd7, 4'd1, 1'b1, 5'd9);
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("rst_hold_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_sum", 32'(out_sum), 32'd0);

    // Idle: nothing issued and nothing reappears after the reset
    for (int c = 0; c < 10; c++) begin
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_add_ops", {23'd0, add_a, add_b, add_ci}, 32'd0);
      @(negedge clk);
    end
    wait_drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_add_issue.md
PIPE_ADD_ISSUE -- requirements
Module: pipe_add_issue

Interface
REQ-001 Parameter LAT, default 4: adder latency in rising edges from operand capture to valid {co,s}; fixed for the 4-bit pipelined adder.
REQ-002 Parameter DEPTH, default 4: result FIFO entries; also the credit limit on in-flight plus buffered operations.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream operand set valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 in_a  input  4  operand A.
REQ-008 in_b  input  4  operand B.
REQ-009 in_ci  input  1  carry-in.
REQ-010 add_a  output  4  operand A to adder.
REQ-011 add_b  output  4  operand B to adder.
REQ-012 add_ci  output  1  carry-in to adder.
REQ-013 add_s  input  4  adder sum.
REQ-014 add_co  input  1  adder carry-out.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  downstream accepts result.
REQ-017 out_sum  output  5  result {co,s}.
REQ-018 busy  output  1  any operation in flight or buffered.

Function
REQ-019 Issue: accept = in_valid && in_ready; add_a/add_b/add_ci SHALL equal in_a/in_b/in_ci combinationally when accept=1, else 4'd0/4'd0/1'b0.
REQ-020 Tracking: LAT-bit tag shift register; tag[0] <= accept each edge, tag[i] <= tag[i-1]; no stalling, the adder has no enable.
REQ-021 Capture: when tag[LAT-1]=1, {add_co,add_s} SHALL be written into the result FIFO on the next edge; accept at edge k -> FIFO write at edge k+LAT.
REQ-022 Credit: in_ready = (popcount(tag) + fifo_count) < DEPTH, from registered state only; a same-cycle pop SHALL NOT raise in_ready in that cycle.
REQ-023 By REQ-022, a capture SHALL never find the FIFO full; no drop path exists.
REQ-024 Output: out_valid = (fifo_count != 0); out_sum = FIFO head; pop when out_valid && out_ready.
REQ-025 FIFO: first-in first-out order preserved; pointers wrap modulo DEPTH; simultaneous push and pop with count in 1..DEPTH-1 leaves count unchanged; simultaneous push and pop at count 0 SHALL NOT occur, since a pop needs out_valid.
REQ-026 fifo_count range 0..DEPTH; it SHALL never exceed DEPTH or underflow.
REQ-027 busy = (tag != 0) || (fifo_count != 0).
REQ-028 Arithmetic: the block performs no addition; out_sum carries the adder result unmodified (5-bit, max 5'd31 = 15+15+1).

Reset
REQ-029 On a rising edge with rstn=0: tag cleared, FIFO pointers and count cleared; after that edge in_ready=1, out_valid=0, busy=0, out_sum=5'd0, add_* = 0.
REQ-030 Reset mid-operation SHALL discard all in-flight and buffered results; stale adder outputs arriving after reset SHALL NOT be captured because tags are clear.
REQ-031 While rstn=0, in_ready SHALL be 0.

Structure
REQ-032 Shared package pipe_add_pkg SHALL hold LAT, DEPTH, operand width 4 and result width 5.
REQ-033 The result FIFO SHALL be a sub-module named pipe_add_fifo (push, pop, data in/out, count); issue and tag logic stay in pipe_add_issue.
REQ-034 The bench instantiates pipe_add_issue with the pipelined adder, driving the adder's rstn from the same reset.

Verification
REQ-035 Single op: a=9, b=8, ci=1 accepted at edge k, out_ready=1 -> out_valid rises after edge k+4 with out_sum=5'd18 for one cycle; busy drops after the pop.
REQ-036 Back-to-back: pairs (15,15,1), (0,0,0), (7,8,0), (3,4,1) on consecutive edges -> outputs 31, 0, 15, 8 in order on consecutive cycles.
REQ-037 Backpressure: out_ready=0, in_valid=1 continuously -> exactly 4 accepts, then in_ready=0; out_ready=1 -> one new accept per pop, no loss, order kept.
REQ-038 Wrap: 12 ops with out_ready toggling every cycle -> all 12 sums correct and in order across pointer wrap.
REQ-039 Reset mid-flight: 2 ops in flight and 1 buffered, rstn=0 for one edge -> out_valid=0, busy=0, and no result appears afterwards.
REQ-040 Idle: in_valid=0 for 10 cycles -> add_a=add_b=0, add_ci=0, out_valid=0.
